counter_scheduler: RTL and testbench
====================================

# counter_scheduler

Round-robin scheduler that shares one WIDTH-bit up/down count engine among NREQ requesters. Each requester asks for a timed interval (direction plus length). The scheduler grants the engine to one requester at a time, runs the count to its terminal value, and returns a one-cycle done pulse. It sits between the control FSMs that need interval timing and the single shared counter datapath, replacing per-client counter instances.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 9, count engine width in bits
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester request level; held high until done or abort
- mode  in  NREQ  per-requester direction: 1 = count up, 0 = count down
- len  in  NREQ*WIDTH  per-requester length; requester i uses bits [i*WIDTH +: WIDTH]
- grant  out  NREQ  one-hot; high for the granted requester while counting
- done  out  NREQ  one-cycle pulse on completion for the granted requester
- abort  out  NREQ  one-cycle pulse when the granted requester withdrew early
- busy  out  1  high whenever state != IDLE
- count  out  WIDTH  current engine value

## Operation
- States: IDLE, RUN, DONE.
- IDLE, any req high:
  - pick winner idx by round-robin; search order ptr+1, ptr+2, …, ptr+NREQ (mod NREQ).
  - latch idx, mode[idx], len[idx]; set ptr <= idx.
  - up: count <= 0, target <= len. Down: count <= len, target <= 0.
  - go to RUN.
- IDLE, no req: stay; count holds its last value.
- RUN:
  - grant[idx] = 1.
  - req[idx] == 0: go to IDLE, pulse abort[idx]. Abort has priority over terminal in the same cycle.
  - else if count == target: go to DONE; count holds.
  - else count +/- 1 per mode.
- DONE:
  - done[idx] = 1, grant = 0.
  - always go to IDLE next.
- Latched mode/len are frozen for the run; changes to inputs mid-run are ignored.
- Arithmetic: unsigned, WIDTH bits. The target is always reached before any wrap, so count never wraps. len = 0 is legal: one RUN cycle.
- A requester must drop req in the cycle done or abort is seen. If req is still high in the following IDLE cycle, it is treated as a new request.
- All outputs are registered or decoded from registered state only; no combinational path from req to grant.

## Timing
- Reset (async, immediate): state = IDLE, ptr = NREQ-1 (requester 0 wins first), grant = 0, done = 0, abort = 0, busy = 0, count = 0.
- Reset mid-run: the run is discarded, no done or abort is pulsed, and the register values listed above apply at once.
- Edge E0 samples req in IDLE. From E0 through E0+len+1, the scheduler is in RUN (len+1 cycles, count = start…target).
- done is high for exactly the cycle after edge E0+len+1.
- Next arbitration happens at edge E0+len+3, giving a minimum 1 IDLE cycle between runs.
- Back-to-back throughput per grant: len+3 cycles.
- Abort: req[idx] sampled low at edge Ek in RUN. abort[idx] is high during the cycle after Ek, with grant = 0 and state = IDLE. Re-arbitration happens at Ek+1.
- busy rises the cycle after E0 and falls in the IDLE cycle after DONE or abort.

## Test plan
- Single up run: req[0] = 1, mode[0] = 1, len = 5 → grant[0] for 6 cycles, count 0,1,2,3,4,5, then done[0] pulses 1 cycle, busy falls after.
- Single down run: req[1] = 1, mode[1] = 0, len = 3 → count 3,2,1,0, then done[1] pulse; grant[1] is never high during done.
- Round-robin fairness: req = 4'b1111 held, all len = 0, each requester drops req on its done → grant order 0,1,2,3, and each grant lasts 1 cycle.
- Abort plus priority: req[2] run, len = 10; drop req[2] when count = 4 → abort[2] pulse, no done. Also drop req exactly at count == target → abort wins, no done.
- Reset mid-run: assert reset while count = 7 → grant, busy, and count go to 0 immediately. After release, req = 4'b1000 plus req[0] → requester 0 is granted first.
- Full range: up, len = 511 → 512 RUN cycles, count reaches 511 with no wrap to 0, then done pulse. Also len = 0 → done on the 2nd cycle after grant sample.

Source files
------------

// File: rtl/counter_scheduler_if.sv
// Request/grant bundle between the interval-timing clients and the shared count engine.
interface counter_scheduler_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 9
) ();
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       mode;
    logic [NREQ*WIDTH-1:0] len;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic [NREQ-1:0]       abort;
    logic                  busy;
    logic [WIDTH-1:0]      count;

    modport master (
        output req, mode, len,
        input  grant, done, abort, busy, count
    );

    modport slave (
        input  req, mode, len,
        output grant, done, abort, busy, count
    );
endinterface

// File: rtl/counter_scheduler.sv
// Round-robin arbiter sharing one up/down interval counter among NREQ requesters.
module counter_scheduler #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 9
) (
    input logic                clk,
    input logic                reset,
    counter_scheduler_if.slave bus
);
    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [IdxW-1:0]  ptr_q;
    logic [IdxW-1:0]  idx_q;
    logic             mode_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] target_q;
    logic [NREQ-1:0]  grant_q;
    logic [NREQ-1:0]  done_q;
    logic [NREQ-1:0]  abort_q;
    logic             busy_q;

    logic [WIDTH-1:0] len_arr [NREQ];
    logic             win_valid;
    logic [IdxW-1:0]  win_idx;
    logic [IdxW-1:0]  cand;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            len_arr[i] = bus.len[i*WIDTH +: WIDTH];
        end
    end

    // First requester found searching from ptr+1 around to ptr itself.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IdxW'((32'(ptr_q) + k) % NREQ);
            if (!win_valid && bus.req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            ptr_q    <= IdxW'(NREQ - 1);
            idx_q    <= '0;
            mode_q   <= 1'b0;
            count_q  <= '0;
            target_q <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            abort_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            done_q  <= '0;
            abort_q <= '0;
            case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        idx_q   <= win_idx;
                        ptr_q   <= win_idx;
                        mode_q  <= bus.mode[win_idx];
                        grant_q <= NREQ'(1) << win_idx;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                        if (bus.mode[win_idx]) begin
                            count_q  <= '0;
                            target_q <= len_arr[win_idx];
                        end else begin
                            count_q  <= len_arr[win_idx];
                            target_q <= '0;
                        end
                    end
                end
                StRun: begin
                    // Withdrawal beats reaching the terminal value.
                    if (!bus.req[idx_q]) begin
                        state_q        <= StIdle;
                        grant_q        <= '0;
                        busy_q         <= 1'b0;
                        abort_q[idx_q] <= 1'b1;
                    end else if (count_q == target_q) begin
                        state_q       <= StDone;
                        grant_q       <= '0;
                        done_q[idx_q] <= 1'b1;
                    end else begin
                        count_q <= mode_q ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.abort = abort_q;
    assign bus.busy  = busy_q;
    assign bus.count = count_q;
endmodule

// File: tb/tb_counter_scheduler.sv
// Scoreboard bench: per-cycle expected outputs are queued with stimulus and popped on negedges.
module tb_counter_scheduler;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 9;

    typedef struct {
        logic [3:0] grant;
        logic [3:0] done;
        logic [3:0] abort;
        logic       busy;
        logic [8:0] count;
        logic [3:0] drop;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   cyc;
    exp_t exp_q[$];

    counter_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    counter_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] pack(logic [3:0] g, logic [3:0] d, logic [3:0] a, logic b,
                                         logic [8:0] c);
        return {10'd0, g, d, a, b, c};
    endfunction

    function automatic void push_cyc(logic [3:0] g, logic [3:0] d, logic [3:0] a, logic b,
                                     int c, logic [3:0] drop);
        exp_t e;
        e.grant = g;
        e.done  = d;
        e.abort = a;
        e.busy  = b;
        e.count = 9'(c);
        e.drop  = drop;
        exp_q.push_back(e);
    endfunction

    // stop < 0: normal run ending in done. stop >= 0: req dropped after step 'stop'.
    function automatic void push_run(int idx, bit up, int n, int stop);
        logic [3:0] oh   = 4'b0001 << idx;
        int         last = (stop >= 0) ? stop : n;
        int         c    = 0;
        for (int i = 0; i <= last; i++) begin
            c = up ? i : n - i;
            push_cyc(oh, 4'b0, 4'b0, 1'b1, c, (i == stop) ? oh : 4'b0);
        end
        if (stop >= 0) begin
            push_cyc(4'b0, 4'b0, oh, 1'b0, c, 4'b0);
        end else begin
            push_cyc(4'b0, oh, 4'b0, 1'b1, up ? n : 0, oh);
            push_cyc(4'b0, 4'b0, 4'b0, 1'b0, up ? n : 0, 4'b0);
        end
    endfunction

    task automatic play();
        exp_t e;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cyc++;
            e = exp_q.pop_front();
            check($sformatf("cycle%0d", cyc),
                  pack(bus.grant, bus.done, bus.abort, bus.busy, bus.count),
                  pack(e.grant, e.done, e.abort, e.busy, e.count));
            bus.req = bus.req & ~e.drop;
        end
    endtask

    task automatic set_req(int idx, bit up, int n);
        bus.mode[idx]              = up;
        bus.len[idx*WIDTH +: WIDTH] = 9'(n);
        bus.req[idx]               = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        reset    = 1'b1;
        bus.req  = '0;
        bus.mode = '0;
        bus.len  = '0;
        #1;
        check("reset_state", pack(bus.grant, bus.done, bus.abort, bus.busy, bus.count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single up run on requester 0.
        set_req(0, 1'b1, 5);
        push_run(0, 1'b1, 5, -1);
        play();

        // Single down run on requester 1; inputs scrambled mid-run must be ignored.
        set_req(1, 1'b0, 3);
        push_run(1, 1'b0, 3, -1);
        @(posedge clk);
        #1;
        bus.mode = 4'b1111;
        bus.len  = {4{9'd200}};
        play();

        // Fairness from reset: all request, len 0, expect order 0,1,2,3.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 0);
        for (int i = 0; i < 4; i++) push_run(i, 1'b1, 0, -1);
        play();

        // Early abort at count 4, then abort coinciding with terminal count.
        set_req(2, 1'b1, 10);
        push_run(2, 1'b1, 10, 4);
        push_cyc(4'b0, 4'b0, 4'b0, 1'b0, 4, 4'b0);
        play();
        set_req(2, 1'b1, 3);
        push_run(2, 1'b1, 3, 3);
        push_cyc(4'b0, 4'b0, 4'b0, 1'b0, 3, 4'b0);
        play();

        // Reset mid-run at count 7, then requester 0 must win over requester 3.
        set_req(0, 1'b1, 20);
        for (int i = 0; i <= 7; i++) push_cyc(4'b0001, 4'b0, 4'b0, 1'b1, i, 4'b0);
        play();
        #1;
        reset = 1'b1;
        #1;
        check("reset_midrun", pack(bus.grant, bus.done, bus.abort, bus.busy, bus.count),
              32'd0);
        bus.req = 4'b1001;
        set_req(0, 1'b1, 2);
        set_req(3, 1'b0, 1);
        @(posedge clk);
        #1;
        check("reset_held", pack(bus.grant, bus.done, bus.abort, bus.busy, bus.count), 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        push_run(0, 1'b1, 2, -1);
        push_run(3, 1'b0, 1, -1);
        play();

        // Full-range up count and a zero-length down run.
        set_req(1, 1'b1, 511);
        push_run(1, 1'b1, 511, -1);
        play();
        set_req(3, 1'b0, 0);
        push_run(3, 1'b0, 0, -1);
        play();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
